// File: rtl/ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ram_slave
//  Purpose  : Bus slave fronting a 32-word RAM. A request is latched on the
//             edge it is seen in IDLE. The access happens on the next edge.
//             A one-cycle registered s_ack follows, and the slave then waits
//             in HOLD until the master drops s_req (four-phase handshake).
//  Options  : define RAM_SLAVE_CLEAR_EN to clear every storage word on reset.
//             Without it, reset leaves storage untouched.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_slave #(
    parameter logic [2:0] BASE_ADDR = 3'b000,
    parameter int         DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_req,
    input  logic              s_wr,
    input  logic [7:0]        s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_ack,
    output logic              s_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [4:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem_q [32];

    // Next-state, request latch, read-data load and write strobe
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Requests for other slaves are ignored silently
                if (s_req && (s_addr[7:5] == BASE_ADDR)) begin
                    wr_d    = s_wr;
                    idx_d   = s_addr[4:0];
                    wdata_d = s_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Only the latched copies are used here, so bus changes
                // after the latch edge cannot affect the transfer
                if (wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = mem_q[idx_q];
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!s_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Ack is the registered image of RESP: high for exactly one cycle
        // starting two edges after the latch edge
        ack_d = (state_q == ST_RESP);
    end

    // Control and data registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RAM_SLAVE_CLEAR_EN
    // Storage array, cleared to zero by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
`else
    // Storage array, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
`endif

    assign s_rdata = rdata_q;
    assign s_ack   = ack_q;
    assign s_busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_slave
//  Purpose  : Directed self-checking bench for ram_slave (BASE_ADDR = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_slave;

    logic       clk;
    logic       reset_n;
    logic       s_req;
    logic       s_wr;
    logic [7:0] s_addr;
    logic [7:0] s_wdata;
    logic [7:0] s_rdata;
    logic       s_ack;
    logic       s_busy;

    int n_cmp = 0;
    int n_err = 0;

    ram_slave #(
        .BASE_ADDR (3'b000),
        .DATA_W    (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_req   (s_req),
        .s_wr    (s_wr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack),
        .s_busy  (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transfer. Inputs change on negedges. One cycle after the
    // latch edge the bus is scrambled (address, direction, data = wd2) so that
    // only the latched values can produce the right result. lat is the number
    // of negedges from request to ack (0 = no ack in budget); acks counts
    // every ack seen, including two cycles after s_req drops.
    task automatic xfer(input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] wd2,
                        output logic [7:0] rd, output int lat, output int acks);
        s_req = 1'b1; s_wr = wr; s_addr = addr; s_wdata = wd;
        lat = 0; acks = 0; rd = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                s_wdata = wd2;
                s_addr  = addr ^ 8'h1F;
                s_wr    = ~wr;
            end
            if (s_ack === 1'b1) begin
                lat = k; rd = s_rdata; acks = 1;
                break;
            end
        end
        s_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (s_ack === 1'b1) acks++;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({s_ack, s_busy, s_rdata} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b busy=%b rdata=%h, expected 0/0/00", s_ack, s_busy, s_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b expected 0", s_busy);
        end
    endtask

    task automatic test_write_read;
        logic [7:0] rd; int lat; int acks;
        xfer(1'b1, 8'h03, 8'hF0, 8'hF0, rd, lat, acks);
        n_cmp++;
        if (lat !== 3 || acks !== 1) begin
            n_err++;
            $display("FAIL wr_ack: latency=%0d acks=%0d, expected 3/1", lat, acks);
        end
        xfer(1'b0, 8'h03, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (lat !== 3 || acks !== 1 || rd !== 8'hF0) begin
            n_err++;
            $display("FAIL rd_03: latency=%0d acks=%0d rdata=%h, expected 3/1/f0", lat, acks, rd);
        end
        // A write must leave s_rdata at the last read value
        xfer(1'b1, 8'h04, 8'h5A, 8'h5A, rd, lat, acks);
        n_cmp++;
        if (s_rdata !== 8'hF0) begin
            n_err++;
            $display("FAIL rdata_hold_on_write: rdata=%h expected f0", s_rdata);
        end
    endtask

    task automatic test_no_match;
        logic [7:0] rd; int lat; int acks; int bad;
        bad = 0;
        s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h23; s_wdata = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_ack !== 1'b0 || s_busy !== 1'b0) bad++;
        end
        s_req = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL nomatch_quiet: %0d cycles with ack/busy high, expected 0", bad);
        end
        @(negedge clk);
        xfer(1'b0, 8'h03, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (rd !== 8'hF0) begin
            n_err++;
            $display("FAIL nomatch_storage: rdata=%h expected f0", rd);
        end
    endtask

    task automatic test_hold;
        logic [7:0] rd; int lat; int acks; int bad;
        bad = 0; lat = 0;
        s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h07; s_wdata = 8'h99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_ack === 1'b1) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL hold_first_ack: latency=%0d expected 3", lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (s_busy !== 1'b1 || s_ack !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL hold_stay: %0d bad cycles (need busy=1 ack=0), expected 0", bad);
        end
        s_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: busy=%b expected 0", s_busy);
        end
        xfer(1'b0, 8'h07, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (lat !== 3 || acks !== 1 || rd !== 8'h99) begin
            n_err++;
            $display("FAIL hold_next: latency=%0d acks=%0d rdata=%h, expected 3/1/99", lat, acks, rd);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] rd; int lat; int acks;
        xfer(1'b1, 8'h1F, 8'h0F, 8'h0F, rd, lat, acks);
        xfer(1'b1, 8'h00, 8'hAA, 8'hAA, rd, lat, acks);
        xfer(1'b0, 8'h1F, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (rd !== 8'h0F) begin
            n_err++;
            $display("FAIL wrap_1f: rdata=%h expected 0f", rd);
        end
        xfer(1'b0, 8'h00, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (rd !== 8'hAA) begin
            n_err++;
            $display("FAIL wrap_00: rdata=%h expected aa", rd);
        end
    endtask

    task automatic test_latch;
        logic [7:0] rd; int lat; int acks;
        xfer(1'b1, 8'h09, 8'h11, 8'h22, rd, lat, acks);
        xfer(1'b0, 8'h09, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (rd !== 8'h11) begin
            n_err++;
            $display("FAIL latch_wdata: rdata=%h expected 11", rd);
        end
        // The write was scrambled to index 0x16 after latching; it must be untouched
        xfer(1'b1, 8'h16, 8'h66, 8'h66, rd, lat, acks);
        xfer(1'b1, 8'h09, 8'h33, 8'h44, rd, lat, acks);
        xfer(1'b0, 8'h16, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (rd !== 8'h66) begin
            n_err++;
            $display("FAIL latch_addr: rdata=%h expected 66", rd);
        end
    endtask

    task automatic test_back_to_back;
        int lat1; int lat2;
        lat1 = 0; lat2 = 0;
        s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h0A; s_wdata = 8'h3C;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_ack === 1'b1) begin lat1 = k; break; end
        end
        s_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_busy !== 1'b0 || s_ack !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: busy=%b ack=%b, expected 0/0", s_busy, s_ack);
        end
        s_req = 1'b1; s_wr = 1'b0; s_addr = 8'h0A;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (s_ack === 1'b1) begin lat2 = k; break; end
        end
        s_req = 1'b0;
        n_cmp++;
        if (lat1 !== 3 || lat2 !== 3 || s_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL b2b: lat1=%0d lat2=%0d rdata=%h, expected 3/3/3c", lat1, lat2, s_rdata);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [7:0] rd; int lat; int acks;
        xfer(1'b1, 8'h05, 8'h77, 8'h77, rd, lat, acks);
        xfer(1'b0, 8'h03, 8'h00, 8'h00, rd, lat, acks);
        s_req = 1'b1; s_wr = 1'b1; s_addr = 8'h05; s_wdata = 8'h55;
        @(negedge clk);
        n_cmp++;
        if (s_busy !== 1'b1 || s_rdata !== 8'hF0) begin
            n_err++;
            $display("FAIL abort_pre: busy=%b rdata=%h, expected 1/f0", s_busy, s_rdata);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (s_ack !== 1'b0 || s_busy !== 1'b0 || s_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL abort_async: ack=%b busy=%b rdata=%h, expected 0/0/00", s_ack, s_busy, s_rdata);
        end
        s_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        xfer(1'b0, 8'h05, 8'h00, 8'h00, rd, lat, acks);
        n_cmp++;
        if (lat !== 3 || acks !== 1) begin
            n_err++;
            $display("FAIL post_reset_accept: latency=%0d acks=%0d, expected 3/1", lat, acks);
        end
        n_cmp++;
`ifdef RAM_SLAVE_CLEAR_EN
        if (rd !== 8'h00) begin
            n_err++;
            $display("FAIL abort_read: rdata=%h expected 00", rd);
        end
`else
        if (rd !== 8'h77) begin
            n_err++;
            $display("FAIL abort_read: rdata=%h expected 77", rd);
        end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        s_req   = 1'b0;
        s_wr    = 1'b0;
        s_addr  = 8'h00;
        s_wdata = 8'h00;
        #1;
        test_reset();
        test_write_read();
        test_no_match();
        test_hold();
        test_wrap();
        test_latch();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
